// File: rtl/vehicle_plant_model.sv
// Closed-loop vehicle/environment plant driven by the self-driving controller's commands.
// Optional PLANT_LOAD_EN adds a direct speed/gap load port for hardware-in-the-loop setup.
module vehicle_plant_model #(
  parameter int unsigned STEP_DIV   = 4,
  parameter int unsigned ACCEL_STEP = 5,
  parameter int unsigned BRAKE_STEP = 10,
  parameter int unsigned MAX_SPEED  = 200,
  parameter int unsigned DIST_SHIFT = 3,
  parameter int unsigned INIT_GAP   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accelerate_car,
  input  logic       unlock_doors,
  input  logic [7:0] lead_speed,
`ifdef PLANT_LOAD_EN
  input  logic       load_en,
  input  logic [7:0] load_speed,
  input  logic [6:0] load_gap,
`endif
  output logic [7:0] car_speed,
  output logic [6:0] leading_distance,
  output logic       doors_open,
  output logic       collision,
  output logic [1:0] plant_state
);

  localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [8:0] ACCEL9 = 9'(ACCEL_STEP);
  localparam logic [8:0] BRAKE9 = 9'(BRAKE_STEP);
  localparam logic [8:0] MAX9   = 9'(MAX_SPEED);
  localparam logic [7:0] MAX8   = 8'(MAX_SPEED);
  localparam logic [6:0] INIT7  = 7'(INIT_GAP);

  typedef enum logic [1:0] {
    STOPPED    = 2'b00,
    MOVING     = 2'b01,
    DOORS_OPEN = 2'b10,
    CRASHED    = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       speed_q, speed_d;
  logic [6:0]       gap_q, gap_d;
  logic             doors_q, doors_d;
  logic             coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;

  logic [8:0]        accel_sum, speed_up, speed_down, speed_cmd;
  logic signed [9:0] diff, delta, raw;
  logic [6:0]        gap_clamped;
  logic              crash_hit;

  assign step = (cnt_q == CNT_LAST);

  // Speed arithmetic at 9 bits so neither saturation nor the brake floor can wrap.
  always_comb begin
    accel_sum  = {1'b0, speed_q} + ACCEL9;
    speed_up   = (accel_sum > MAX9) ? MAX9 : accel_sum;
    speed_down = ({1'b0, speed_q} > BRAKE9) ? ({1'b0, speed_q} - BRAKE9) : '0;
    speed_cmd  = accelerate_car ? speed_up : speed_down;
  end

  // Gap change is the scaled closing speed; the arithmetic shift rounds toward -inf.
  always_comb begin
    diff      = $signed({2'b00, lead_speed}) - $signed({2'b00, speed_q});
    delta     = diff >>> DIST_SHIFT;
    raw       = $signed({3'b000, gap_q}) + delta;
    crash_hit = (raw <= 10'sd0) && (speed_q != '0);
    if (raw < 10'sd0)
      gap_clamped = '0;
    else if (raw > 10'sd127)
      gap_clamped = '1;
    else
      gap_clamped = raw[6:0];
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    gap_d   = gap_q;
    doors_d = doors_q;
    coll_d  = coll_q;
    cnt_d   = step ? '0 : cnt_q + 1'b1;

    if (step && (state_q != CRASHED)) begin
      if (crash_hit) begin
        state_d = CRASHED;
        coll_d  = 1'b1;
        gap_d   = '0;
        speed_d = '0;
        doors_d = 1'b0;
      end else begin
        gap_d = gap_clamped;
        case (state_q)
          STOPPED: begin
            if (unlock_doors) begin
              state_d = DOORS_OPEN;
              doors_d = 1'b1;
              speed_d = '0;
            end else if (accelerate_car) begin
              state_d = MOVING;
              speed_d = speed_up[7:0];
            end
          end
          MOVING: begin
            speed_d = speed_cmd[7:0];
            if (speed_cmd == '0)
              state_d = STOPPED;
          end
          DOORS_OPEN: begin
            speed_d = '0;
            if (!unlock_doors) begin
              state_d = STOPPED;
              doors_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

`ifdef PLANT_LOAD_EN
    // A load overrides stepping on any edge and restarts the step phase.
    if (load_en) begin
      speed_d = (load_speed > MAX8) ? MAX8 : load_speed;
      gap_d   = load_gap;
      state_d = (load_speed != '0) ? MOVING : STOPPED;
      coll_d  = 1'b0;
      doors_d = 1'b0;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOPPED;
      speed_q <= '0;
      gap_q   <= INIT7;
      doors_q <= 1'b0;
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      gap_q   <= gap_d;
      doors_q <= doors_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
    end
  end

  assign car_speed        = speed_q;
  assign leading_distance = gap_q;
  assign doors_open       = doors_q;
  assign collision        = coll_q;
  assign plant_state      = state_q;

endmodule

// File: tb/tb_vehicle_plant_model.sv
// Directed bench for vehicle_plant_model with default parameters (STEP_DIV=4).
module tb_vehicle_plant_model;

  logic       clk;
  logic       rst;
  logic       accelerate_car;
  logic       unlock_doors;
  logic [7:0] lead_speed;
`ifdef PLANT_LOAD_EN
  logic       load_en;
  logic [7:0] load_speed;
  logic [6:0] load_gap;
`endif
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       doors_open;
  logic       collision;
  logic [1:0] plant_state;

  int tests = 0;
  int fails = 0;

  vehicle_plant_model dut (
    .clk              (clk),
    .rst              (rst),
    .accelerate_car   (accelerate_car),
    .unlock_doors     (unlock_doors),
    .lead_speed       (lead_speed),
`ifdef PLANT_LOAD_EN
    .load_en          (load_en),
    .load_speed       (load_speed),
    .load_gap         (load_gap),
`endif
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .doors_open       (doors_open),
    .collision        (collision),
    .plant_state      (plant_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int spd, input int gap, input int st,
                         input int drs, input int col);
    chk({tag, ".speed"}, 32'(car_speed), spd);
    chk({tag, ".gap"},   32'(leading_distance), gap);
    chk({tag, ".state"}, 32'(plant_state), st);
    chk({tag, ".doors"}, 32'(doors_open), drs);
    chk({tag, ".coll"},  32'(collision), col);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    edges(4 * n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    accelerate_car = 1'b0;
    unlock_doors   = 1'b0;
    lead_speed     = 8'd0;
`ifdef PLANT_LOAD_EN
    load_en    = 1'b0;
    load_speed = 8'd0;
    load_gap   = 7'd0;
`endif

    // Reset state and first-step latency.
    do_reset();
    chk_all("reset", 0, 50, 0, 0, 0);
    accelerate_car = 1'b1;
    lead_speed     = 8'd40;
    edges(3);
    chk("latency.hold", 32'(car_speed), 0);
    edges(1);
    chk_all("accel.s1", 5, 55, 1, 0, 0);
    edges(2);
    chk("accel.between", 32'(car_speed), 5);
    edges(2);
    chk("accel.s2", 32'(car_speed), 10);
    chk("accel.s2gap", 32'(leading_distance), 59);
    for (int k = 3; k <= 10; k++) begin
      steps(1);
      chk("accel.speed", 32'(car_speed), 32'(5 * k));
    end
    chk_all("accel.s10", 50, 68, 1, 0, 0);

    // Saturation, gap clamped at the top with a fast leader.
    lead_speed = 8'd255;
    steps(29);
    chk("sat.s39", 32'(car_speed), 195);
    steps(1);
    chk("sat.s40", 32'(car_speed), 200);
    steps(5);
    chk_all("sat.s45", 200, 127, 1, 0, 0);

    // Braking from 25 down to a stop without underflow.
    do_reset();
    lead_speed = 8'd40;
    steps(5);
    chk_all("brk.pre", 25, 67, 1, 0, 0);
    accelerate_car = 1'b0;
    steps(1);
    chk_all("brk.b1", 15, 68, 1, 0, 0);
    steps(1);
    chk_all("brk.b2", 5, 71, 1, 0, 0);
    steps(1);
    chk_all("brk.b3", 0, 75, 0, 0, 0);
    steps(1);
    chk_all("brk.b4", 0, 80, 0, 0, 0);

    // Doors beat accelerate; closing returns to STOPPED before moving.
    unlock_doors   = 1'b1;
    accelerate_car = 1'b1;
    steps(1);
    chk_all("door.open", 0, 85, 2, 1, 0);
    steps(1);
    chk_all("door.hold", 0, 90, 2, 1, 0);
    unlock_doors = 1'b0;
    steps(1);
    chk_all("door.close", 0, 95, 0, 0, 0);
    steps(1);
    chk_all("door.go", 5, 100, 1, 0, 0);
    unlock_doors = 1'b1;
    steps(1);
    chk_all("door.ignored", 10, 104, 1, 0, 0);
    unlock_doors = 1'b0;

    // Mid-step reset while moving at 60; negative delta rounds toward -inf.
    do_reset();
    lead_speed = 8'd40;
    steps(12);
    chk_all("mid.pre", 60, 64, 1, 0, 0);
    edges(2);
    do_reset();
    chk_all("mid.rst", 0, 50, 0, 0, 0);
    edges(3);
    chk("mid.hold", 32'(car_speed), 0);
    edges(1);
    chk("mid.first", 32'(car_speed), 5);

    // Collision by closing on a stationary leader, then freeze and reset.
    do_reset();
    lead_speed = 8'd0;
    steps(12);
    chk_all("crash.pre", 60, 4, 1, 0, 0);
    steps(1);
    chk_all("crash.hit", 0, 0, 3, 0, 1);
    lead_speed     = 8'd255;
    unlock_doors   = 1'b1;
    accelerate_car = 1'b0;
    steps(3);
    chk_all("crash.frozen", 0, 0, 3, 0, 1);
    unlock_doors = 1'b0;
    do_reset();
    chk_all("crash.rst", 0, 50, 0, 0, 0);

`ifdef PLANT_LOAD_EN
    // Load: speed 200 gap 50 closing on a 120 leader crashes at step 5.
    accelerate_car = 1'b1;
    lead_speed     = 8'd120;
    edges(2);
    load_en    = 1'b1;
    load_speed = 8'd200;
    load_gap   = 7'd50;
    edges(1);
    load_en = 1'b0;
    chk_all("load.init", 200, 50, 1, 0, 0);
    steps(1);
    chk_all("load.s1", 200, 40, 1, 0, 0);
    steps(3);
    chk_all("load.s4", 200, 10, 1, 0, 0);
    steps(1);
    chk_all("load.s5", 0, 0, 3, 0, 1);
    load_en    = 1'b1;
    load_speed = 8'd255;
    load_gap   = 7'd90;
    edges(1);
    load_en = 1'b0;
    chk_all("load.clamp", 200, 90, 1, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
